// File: rtl/counter_run_ctrl.sv
// Run-control sequencer for the board counter: conditions start/stop/step buttons
// and issues prescaled single-cycle enable pulses, with optional one-shot halt.
module counter_run_ctrl #(
  parameter int unsigned COUNTER_BITWIDTH   = 4,
  parameter int unsigned COUNTER_MAX        = 15,
  parameter int unsigned PRESCALER_BITWIDTH = 24,
  parameter int unsigned PRESCALER_MAX      = 11999999
) (
  input  logic                        clock_i,
  input  logic                        reset_n_i,
  input  logic                        start_i,
  input  logic                        stop_i,
  input  logic                        step_i,
  input  logic                        oneshot_i,
  input  logic [COUNTER_BITWIDTH-1:0] counter_value_i,
  output logic                        enable_o,
  output logic                        running_o,
  output logic                        done_o,
  output logic [1:0]                  state_o
);

  localparam int unsigned CW      = COUNTER_BITWIDTH;
  localparam int unsigned PW      = PRESCALER_BITWIDTH;
  localparam int unsigned BTN_NUM = 3;

  localparam logic [PW-1:0] PRESC_TOP = PW'(PRESCALER_MAX);
  localparam logic [CW-1:0] COUNT_TOP = CW'(COUNTER_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_STOP,
    CMD_START,
    CMD_STEP
  } cmd_t;

  // Button bit order: [0]=start, [1]=stop, [2]=step
  logic [BTN_NUM-1:0] btn_raw;
  logic [BTN_NUM-1:0] btn_sync1;
  logic [BTN_NUM-1:0] btn_sync2;
  logic [BTN_NUM-1:0] btn_prev;
  logic [BTN_NUM-1:0] btn_pulse;

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_next;
  logic          enable_q;
  logic          enable_next;
  logic          running_q;
  logic          running_next;
  logic          done_q;
  logic          done_next;

  cmd_t          cmd;
  logic          tick;
  logic          hit_top;

  assign btn_raw = {step_i, stop_i, start_i};

  // Two-flop synchronizer followed by a registered rising-edge detector
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      btn_sync1 <= '0;
      btn_sync2 <= '0;
      btn_prev  <= '0;
      btn_pulse <= '0;
    end else begin
      btn_sync1 <= btn_raw;
      btn_sync2 <= btn_sync1;
      btn_prev  <= btn_sync2;
      btn_pulse <= btn_sync2 & ~btn_prev;
    end
  end

  // Only the highest-priority pulse acts: stop > start > step
  always_comb begin
    cmd = CMD_NONE;
    if (btn_pulse[1]) begin
      cmd = CMD_STOP;
    end else if (btn_pulse[0]) begin
      cmd = CMD_START;
    end else if (btn_pulse[2]) begin
      cmd = CMD_STEP;
    end
  end

  assign tick = (presc == PRESC_TOP);

  // Counter readback lags enable by one edge, so only trust it on non-pulse cycles
  assign hit_top = oneshot_i && (counter_value_i == COUNT_TOP) && !enable_q;

  // State, prescaler and registered outputs
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state     <= IDLE;
      presc     <= '0;
      enable_q  <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_next;
      presc     <= presc_next;
      enable_q  <= enable_next;
      running_q <= running_next;
      done_q    <= done_next;
    end
  end

  // Next-state and prescaler update
  always_comb begin
    state_next = state;
    presc_next = presc;
    case (state)
      IDLE: begin
        if (cmd == CMD_START) begin
          state_next = RUN;
          presc_next = '0;
        end
      end
      RUN: begin
        if (cmd == CMD_STOP) begin
          state_next = PAUSE;
        end else if (hit_top) begin
          state_next = DONE;
          presc_next = '0;
        end else if (tick) begin
          presc_next = '0;
        end else begin
          presc_next = presc + PW'(1);
        end
      end
      PAUSE: begin
        if (cmd == CMD_STOP) begin
          state_next = IDLE;
          presc_next = '0;
        end else if (cmd == CMD_START) begin
          state_next = RUN;
        end
      end
      DONE: begin
        if (cmd == CMD_STOP) begin
          state_next = IDLE;
          presc_next = '0;
        end else if (cmd == CMD_START) begin
          state_next = RUN;
          presc_next = '0;
        end
      end
    endcase
  end

  // Output decode, registered on the same edge as the state
  always_comb begin
    enable_next  = 1'b0;
    running_next = (state_next == RUN);
    done_next    = (state_next == DONE);
    case (state)
      IDLE:    enable_next = (cmd == CMD_STEP);
      RUN:     enable_next = (cmd != CMD_STOP) && !hit_top && tick;
      PAUSE:   enable_next = (cmd == CMD_STEP);
      DONE:    enable_next = 1'b0;
    endcase
  end

  assign enable_o  = enable_q;
  assign running_o = running_q;
  assign done_o    = done_q;
  assign state_o   = state;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Scoreboard bench for counter_run_ctrl with a 4-bit counter as its load;
// enable pulse times are queued by the stimulus and checked by a monitor.
module tb_counter_run_ctrl;

  localparam int unsigned CW = 4;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          stop;
  logic          step;
  logic          oneshot;
  logic [CW-1:0] cnt;
  logic          cnt_rst_n;
  logic          enable;
  logic          running;
  logic          done;
  logic [1:0]    state;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int exp_q[$];
  int mon_exp;
  int k;

  counter_run_ctrl #(
    .COUNTER_BITWIDTH  (CW),
    .COUNTER_MAX       (15),
    .PRESCALER_BITWIDTH(24),
    .PRESCALER_MAX     (3)
  ) dut (
    .clock_i        (clk),
    .reset_n_i      (reset_n),
    .start_i        (start),
    .stop_i         (stop),
    .step_i         (step),
    .oneshot_i      (oneshot),
    .counter_value_i(cnt),
    .enable_o       (enable),
    .running_o      (running),
    .done_o         (done),
    .state_o        (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Load counter, reset independently of the sequencer
  always @(posedge clk) begin
    if (!cnt_rst_n) cnt <= '0;
    else if (enable) cnt <= cnt + 4'd1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic at(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic clr_cnt();
    cnt_rst_n = 1'b0;
    @(negedge clk);
    cnt_rst_n = 1'b1;
  endtask

  // Monitor: every enable pulse must match the next queued cycle number
  always @(negedge clk) begin
    if (enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_enable: pulse at cycle %0d, none expected", cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("enable_time", cyc, mon_exp);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; cnt_rst_n = 1'b0;
    start = 1'b0; stop = 1'b0; step = 1'b0; oneshot = 1'b0;
    at(3);
    chk("rst_state", int'(state), 0);
    chk("rst_enable", int'(enable), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_done", int'(done), 0);
    reset_n = 1'b1; cnt_rst_n = 1'b1;
    at(6);

    // Start and count 1,2,3; held button gives no extra pulse
    k = cyc;
    start = 1'b1;
    exp_q.push_back(k + 8); exp_q.push_back(k + 12);
    exp_q.push_back(k + 16); exp_q.push_back(k + 20);
    at(k + 3);  chk("s1_state_pre", int'(state), 0);
    at(k + 4);  chk("s1_state_run", int'(state), 1); chk("s1_running", int'(running), 1);
    at(k + 9);  chk("s1_cnt1", int'(cnt), 1);
    at(k + 10); start = 1'b0;
    at(k + 13); chk("s1_cnt2", int'(cnt), 2);
    at(k + 17); chk("s1_cnt3", int'(cnt), 3); stop = 1'b1;
    at(k + 19); stop = 1'b0;
    at(k + 21); chk("s1_pause", int'(state), 2); chk("s1_cnt4", int'(cnt), 4);
    at(k + 25); stop = 1'b1;
    at(k + 27); stop = 1'b0;
    at(k + 29); chk("s1_idle", int'(state), 0);
    clr_cnt();
    at(cyc + 2);

    // Pause with prescaler at 1, hold, resume: next pulse 3 cycles later
    k = cyc;
    start = 1'b1;
    exp_q.push_back(k + 8); exp_q.push_back(k + 12);
    exp_q.push_back(k + 41); exp_q.push_back(k + 45); exp_q.push_back(k + 49);
    at(k + 2);  start = 1'b0;
    at(k + 10); stop = 1'b1;
    at(k + 12); stop = 1'b0;
    at(k + 14); chk("s2_pause", int'(state), 2);
    at(k + 24); chk("s2_frozen_a", int'(cnt), 2);
    at(k + 34); start = 1'b1;
    at(k + 36); start = 1'b0;
    at(k + 37); chk("s2_frozen_b", int'(cnt), 2); chk("s2_still_pause", int'(state), 2);
    at(k + 38); chk("s2_resume", int'(state), 1);
    at(k + 42); chk("s2_cnt3", int'(cnt), 3);
    at(k + 46); stop = 1'b1;
    at(k + 48); stop = 1'b0;
    at(k + 54); stop = 1'b1;
    at(k + 56); stop = 1'b0;
    at(k + 58); chk("s2_idle", int'(state), 0); chk("s2_cnt5", int'(cnt), 5);
    clr_cnt();
    at(cyc + 2);

    // One-shot: 15 pulses then DONE; restart with oneshot cleared wraps to 0
    k = cyc;
    oneshot = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 15; i++) exp_q.push_back(k + 8 + 4 * i);
    at(k + 2);   start = 1'b0;
    at(k + 65);  chk("s3_cnt15", int'(cnt), 15); chk("s3_run_lag", int'(state), 1);
    at(k + 66);  chk("s3_done_state", int'(state), 3); chk("s3_done", int'(done), 1);
    chk("s3_running_off", int'(running), 0);
    at(k + 166); chk("s3_hold_state", int'(state), 3); chk("s3_hold_cnt", int'(cnt), 15);
    oneshot = 1'b0;
    start = 1'b1;
    exp_q.push_back(k + 174); exp_q.push_back(k + 178);
    at(k + 168); start = 1'b0;
    at(k + 170); chk("s3_restart", int'(state), 1);
    at(k + 175); chk("s3_wrap", int'(cnt), 0);
    at(k + 176); stop = 1'b1;
    at(k + 178); stop = 1'b0;
    at(k + 184); stop = 1'b1;
    at(k + 186); stop = 1'b0;
    at(k + 188); chk("s3_idle", int'(state), 0);
    clr_cnt();
    at(cyc + 2);

    // Step in IDLE three times, each held 10 cycles
    k = cyc;
    for (int i = 0; i < 3; i++) begin
      at(k + 20 * i);
      step = 1'b1;
      exp_q.push_back(k + 20 * i + 4);
      at(k + 20 * i + 10);
      step = 1'b0;
    end
    at(k + 45); chk("s4_cnt3", int'(cnt), 3); chk("s4_idle", int'(state), 0);
    clr_cnt();
    at(cyc + 2);

    // Same-cycle start+stop: stop wins in RUN, nothing happens in IDLE
    k = cyc;
    start = 1'b1;
    exp_q.push_back(k + 8); exp_q.push_back(k + 12);
    at(k + 2);  start = 1'b0;
    at(k + 10); start = 1'b1; stop = 1'b1;
    at(k + 12); start = 1'b0; stop = 1'b0;
    at(k + 14); chk("s5_run_pause", int'(state), 2);
    at(k + 18); stop = 1'b1;
    at(k + 20); stop = 1'b0;
    at(k + 22); chk("s5_to_idle", int'(state), 0);
    at(k + 26); start = 1'b1; stop = 1'b1;
    at(k + 28); start = 1'b0; stop = 1'b0;
    at(k + 30); chk("s5_idle_a", int'(state), 0);
    at(k + 40); chk("s5_idle_b", int'(state), 0); chk("s5_not_running", int'(running), 0);
    clr_cnt();
    at(cyc + 2);

    // Reset one edge before the first tick: no pulse, back to IDLE
    k = cyc;
    start = 1'b1;
    at(k + 2);  start = 1'b0;
    at(k + 4);  chk("s6_run", int'(state), 1);
    at(k + 7);  reset_n = 1'b0;
    at(k + 8);  reset_n = 1'b1;
    chk("s6_rst_enable", int'(enable), 0); chk("s6_rst_state", int'(state), 0);
    chk("s6_rst_running", int'(running), 0);
    at(k + 12); chk("s6_stay_idle", int'(state), 0); start = 1'b1;
    exp_q.push_back(k + 20); exp_q.push_back(k + 24); exp_q.push_back(k + 28);
    at(k + 14); start = 1'b0;
    at(k + 16); chk("s6_rerun", int'(state), 1);
    at(k + 30); reset_n = 1'b0;
    at(k + 32); reset_n = 1'b1; chk("s6_final_state", int'(state), 0);
    chk("s6_cnt3", int'(cnt), 3);

    at(k + 45);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
